// File: rtl/ddr_burst_responder.sv
// rtl/ddr_burst_responder.sv - memory-side responder for the rd/wr burst protocol
// Optional DDR_RESP_BACKPRESSURE_EN inserts one stall cycle after every 4th beat.
module ddr_burst_responder #(
    parameter int DDR_DATA_WIDTH = 128,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int MEM_DEPTH      = 1024,
    parameter int ADDR_SHIFT     = 3,
    parameter int RD_LATENCY     = 2
) (
    input  logic                      mem_clk,
    input  logic                      rst,
    input  logic                      rd_burst_req,
    input  logic                      wr_burst_req,
    input  logic [9:0]                rd_burst_len,
    input  logic [9:0]                wr_burst_len,
    input  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
    input  logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
    output logic                      rd_burst_data_valid,
    output logic                      wr_burst_data_req,
    output logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
    input  logic [DDR_DATA_WIDTH-1:0] wr_burst_data,
    output logic                      rd_burst_finish,
    output logic                      wr_burst_finish,
    output logic                      busy
);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [RD_LATENCY-1:0] V_LAST = RD_LATENCY'(1) << (RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_BURST, S_WR_END, S_RD_BURST, S_RD_DRAIN, S_RD_END
    } state_t;

    state_t                    state_q, state_d;
    logic [9:0]                len_q, len_d, cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d, wr_widx_q, wr_widx_d;
    logic                      wr_pend_q, wr_pend_d, stall_q, stall_d;
    logic [RD_LATENCY-1:0]     vpipe_q, vpipe_d;
    logic [DDR_DATA_WIDTH-1:0] dpipe_q [RD_LATENCY];
    logic [DDR_DATA_WIDTH-1:0] dpipe_d [RD_LATENCY];
    logic [DDR_DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                      wr_beat, rd_issue;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        stall_d  = 1'b0;
        wr_beat  = 1'b0;
        rd_issue = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_burst_req) begin
                    len_d   = wr_burst_len;
                    idx_d   = IW'(wr_burst_addr >> ADDR_SHIFT);
                    cnt_d   = 10'd0;
                    state_d = (wr_burst_len == 10'd0) ? S_WR_END : S_WR_BURST;
                end else if (rd_burst_req) begin
                    len_d   = rd_burst_len;
                    idx_d   = IW'(rd_burst_addr >> ADDR_SHIFT);
                    cnt_d   = 10'd0;
                    state_d = (rd_burst_len == 10'd0) ? S_RD_END : S_RD_BURST;
                end
            end
            // The final write beat's data is captured on the edge that leaves this state.
            S_WR_BURST: begin
                if (cnt_q == len_q) state_d = S_WR_END;
                else if (!stall_q)  wr_beat = 1'b1;
            end
            S_RD_BURST: begin
                if (!stall_q) begin
                    rd_issue = 1'b1;
                    if (cnt_q + 10'd1 == len_q) state_d = S_RD_DRAIN;
                end
            end
            // Leave once the beat now on the output is the only one in flight.
            S_RD_DRAIN: if ((vpipe_q & ~V_LAST) == '0) state_d = S_RD_END;
            S_WR_END:   state_d = S_IDLE;
            S_RD_END:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (wr_beat || rd_issue) begin
            cnt_d = cnt_q + 10'd1;
            idx_d = idx_q + 1'b1;
`ifdef DDR_RESP_BACKPRESSURE_EN
            stall_d = (cnt_d[1:0] == 2'b00);
`endif
        end
    end

    always_comb begin
        wr_pend_d  = wr_beat;
        wr_widx_d  = idx_q;
        vpipe_d    = vpipe_q << 1;
        vpipe_d[0] = rd_issue;
        dpipe_d[0] = rd_issue ? mem[idx_q] : dpipe_q[0];
        for (int k = 1; k < RD_LATENCY; k++) begin
            dpipe_d[k] = vpipe_q[k-1] ? dpipe_q[k-1] : dpipe_q[k];
        end
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            wr_widx_q <= '0;
            wr_pend_q <= 1'b0;
            stall_q   <= 1'b0;
            vpipe_q   <= '0;
            for (int k = 0; k < RD_LATENCY; k++) dpipe_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wr_widx_q <= wr_widx_d;
            wr_pend_q <= wr_pend_d;
            stall_q   <= stall_d;
            vpipe_q   <= vpipe_d;
            for (int k = 0; k < RD_LATENCY; k++) dpipe_q[k] <= dpipe_d[k];
        end
    end

    // Array contents survive reset; a pending beat is dropped if reset hits mid-burst.
    always_ff @(posedge mem_clk) begin
        if (wr_pend_q) mem[wr_widx_q] <= wr_burst_data;
    end

    assign wr_burst_data_req   = wr_beat;
    assign rd_burst_data_valid = vpipe_q[RD_LATENCY-1];
    assign rd_burst_data       = dpipe_q[RD_LATENCY-1];
    assign wr_burst_finish     = (state_q == S_WR_END);
    assign rd_burst_finish     = (state_q == S_RD_END);
    assign busy                = (state_q != S_IDLE);
endmodule
